addr_job_arbiter: RTL
=====================

# addr_job_arbiter

- Shares one linear AXI address generator between `NUM_CLIENTS` DMA requesters, such as texture, framebuffer and display streams.
- Each client posts a job as a byte range `[startAddr, endAddr)`.
- A round-robin scheduler picks one job at a time, drives the generator's start/done handshake, tags the burst ID with the client index and signals completion back to the owning client.
- Sits between the stream clients and the generator in the memory subsystem.

## Interface
Parameters:
- `NUM_CLIENTS`, 4 — number of requesters, 2..8
- `ADDR_WIDTH`, 32 — address width
- `ID_WIDTH`, 8 — width of `gen_id`; must be ≥ clog2(`NUM_CLIENTS`)
- `BURST_BYTES`, 128 — bytes per generator burst ((axlen+1)·2^axsize); must be a power of two

Ports:
- `aclk` in 1 — clock; all logic on rising edge
- `reset` in 1 — synchronous, active-high reset
- `req_valid` in `NUM_CLIENTS` — client i has a job pending; held until `req_ready[i]`
- `req_start_addr` in `NUM_CLIENTS*ADDR_WIDTH` — flattened; client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_end_addr` in `NUM_CLIENTS*ADDR_WIDTH` — flattened, exclusive end address
- `req_ready` out `NUM_CLIENTS` — one-cycle pulse: job accepted
- `req_done` out `NUM_CLIENTS` — one-cycle pulse: job's address phase finished
- `req_err` out `NUM_CLIENTS` — one-cycle pulse: job rejected (only with the alignment check compiled in)
- `gen_start` out 1 — start request to the generator
- `gen_done` in 1 — generator idle/done flag (high when idle)
- `gen_start_addr`, `gen_end_addr` out `ADDR_WIDTH` — job range driven to the generator
- `gen_id` out `ID_WIDTH` — granted client index, zero-extended; used as axid
- `busy` out 1 — high in any state other than IDLE

## Operation
State machine: IDLE → LAUNCH → WAIT_LOW → WAIT_DONE → COMPLETE → IDLE.

- **IDLE:**
  - If any `req_valid` is set, grant the first set bit at or after round-robin pointer `rr`, searching upward modulo `NUM_CLIENTS`.
  - Latch the grant index into `gnt`, latch that client's addresses, and drive `gen_id` = `gnt`.
  - Pulse `req_ready[gnt]`.
  - Zero-length job (start == end): go straight to COMPLETE; `gen_start` is never asserted.
  - Otherwise go to LAUNCH.
- **LAUNCH:**
  - Hold `gen_start` = 1.
  - Leave for WAIT_LOW on the first edge where `gen_done` = 1; that is the edge the generator accepts the job.
  - If the generator is still busy, `gen_start` stays high.
- **WAIT_LOW:** `gen_start` = 0. Wait for `gen_done` = 0, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `gen_done` = 1, then go to COMPLETE.
- **COMPLETE:**
  - Pulse `req_done[gnt]` for exactly one cycle.
  - Set `rr` = (`gnt` + 1) mod `NUM_CLIENTS`.
  - Return to IDLE.
- **Simultaneous requests:** resolved strictly by `rr`. After client k is served, client k has the lowest priority.
- **New request while busy:** a `req_valid` asserted while not IDLE waits; it is not dropped.
- **Grant index:** `gnt` is never out of range, because the grant search is modulo `NUM_CLIENTS`.
- **Address stability:** `gen_start_addr` and `gen_end_addr` stay stable from IDLE exit until the next grant.

## Timing
- Reset values:
  - all `req_ready`, `req_done`, `req_err` = 0
  - `gen_start` = 0, `busy` = 0
  - `gen_id`, `gen_start_addr`, `gen_end_addr` = 0
  - `rr` = 0, state = IDLE
- Reset mid-job:
  - Abandons the job with no `req_done`.
  - The generator shares the same reset domain and is reset alongside.
- Outputs are registered.
- Latency, with the request sampled at edge E0:
  - `req_ready` and `gen_start` high in cycle E0+1.
  - If the generator is idle, `gen_done` falls in cycle E0+2.
  - `req_done` is high in the cycle after COMPLETE is entered, i.e. 2 cycles after `gen_done` returns high.
- Zero-length job: `req_ready` at E0+1, `req_done` at E0+2.
- Back-to-back jobs: the next grant can occur in the cycle `req_done` is high. This gives a minimum 1-cycle IDLE gap.
- Address arithmetic:
  - Addresses are unsigned `ADDR_WIDTH`.
  - No wrap handling: a job with end < start is forwarded as-is. The caller must not issue one.

## Configuration
- `ADDR_JOB_ARBITER_ALIGN_CHECK_EN`
- **Defined:**
  - In IDLE, a granted job is rejected if `start_addr` or (`end_addr` − `start_addr`) is not a multiple of `BURST_BYTES`.
  - A rejected job pulses `req_ready[gnt]` and `req_err[gnt]` in the same cycle.
  - It produces no `req_done` and no `gen_start`, and sets `rr` = `gnt` + 1.
  - State stays IDLE.
- **Undefined:**
  - `req_err` is tied to 0 and the jobs are forwarded unchecked.
  - Misaligned ranges then never match in the generator; this is a system-level contract.

## Test plan
- **Single job:** client 0, start 0x1000, end 0x1200, generator model with 4 bursts → one `gen_start` cycle, `gen_id` = 0, exactly one `req_done[0]`, `busy` low afterwards.
- **Fairness:** all 4 clients valid continuously with 0x100-byte jobs → grant order 0,1,2,3,0,1; `rr` rotates after each COMPLETE.
- **Zero-length:** client 2, start = end = 0x4000 → `req_ready[2]` at E0+1, `req_done[2]` at E0+2, `gen_start` never high.
- **Busy generator:** `gen_done` held low for 5 cycles when LAUNCH is entered → `gen_start` held high for those 5 cycles; the job is accepted on the first cycle with `gen_done` = 1.
- **Reset mid-job:** `reset` high during WAIT_DONE → all outputs 0 next cycle, no `req_done`; a subsequent client-3 request is granted normally with `rr` = 0.
- **Alignment check** (`ADDR_JOB_ARBITER_ALIGN_CHECK_EN` defined): client 1, start 0x1040, end 0x1100 → `req_err[1]` and `req_ready[1]` pulse together, no `gen_start`; without the macro the same job is launched.

Source files
------------

// File: rtl/addr_job_arbiter_if.sv
// Job-request and address-generator handshake bundle for addr_job_arbiter.
// The master side is the client/generator environment; the slave side is the arbiter.
interface addr_job_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 8
);
  logic [NUM_CLIENTS-1:0]            req_valid;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_start_addr;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_end_addr;
  logic [NUM_CLIENTS-1:0]            req_ready;
  logic [NUM_CLIENTS-1:0]            req_done;
  logic [NUM_CLIENTS-1:0]            req_err;
  logic                              gen_start;
  logic                              gen_done;
  logic [ADDR_WIDTH-1:0]             gen_start_addr;
  logic [ADDR_WIDTH-1:0]             gen_end_addr;
  logic [ID_WIDTH-1:0]               gen_id;
  logic                              busy;

  modport master (
    output req_valid, req_start_addr, req_end_addr, gen_done,
    input  req_ready, req_done, req_err, gen_start, gen_start_addr, gen_end_addr, gen_id, busy
  );

  modport slave (
    input  req_valid, req_start_addr, req_end_addr, gen_done,
    output req_ready, req_done, req_err, gen_start, gen_start_addr, gen_end_addr, gen_id, busy
  );
endinterface

// File: rtl/addr_job_arbiter.sv
// Round-robin arbiter sharing one linear address generator between NUM_CLIENTS job requesters.
// Optional burst-alignment rejection is compiled in with ADDR_JOB_ARBITER_ALIGN_CHECK_EN.
module addr_job_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int BURST_BYTES = 128
) (
  input  logic               aclk,
  input  logic               reset,
  addr_job_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_CLIENTS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]     gen_id_q, gen_id_d;
  logic [ADDR_WIDTH-1:0]   gen_start_addr_q, gen_start_addr_d;
  logic [ADDR_WIDTH-1:0]   gen_end_addr_q, gen_end_addr_d;
  logic                    gen_start_q, gen_start_d;
  logic                    busy_q, busy_d;
  logic [NUM_CLIENTS-1:0]  req_ready_q, req_ready_d;
  logic [NUM_CLIENTS-1:0]  req_done_q, req_done_d;
  logic [NUM_CLIENTS-1:0]  req_err_q, req_err_d;

  logic [ADDR_WIDTH-1:0]   start_arr_s [NUM_CLIENTS];
  logic [ADDR_WIDTH-1:0]   end_arr_s   [NUM_CLIENTS];
  logic [IDX_W-1:0]        pick_s;
  logic [ADDR_WIDTH-1:0]   sel_start_s;
  logic [ADDR_WIDTH-1:0]   sel_end_s;
  logic                    misalign_s;

  // First requester at or after ptr, searching upward modulo NUM_CLIENTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] v,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      j = (int'(ptr) + k) % NUM_CLIENTS;
      if (!found && v[IDX_W'(j)]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(NUM_CLIENTS - 1)) begin
      return '0;
    end else begin
      return g + 1'b1;
    end
  endfunction

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign start_arr_s[g] = bus.req_start_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign end_arr_s[g]   = bus.req_end_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign pick_s      = rr_pick(bus.req_valid, rr_q);
  assign sel_start_s = start_arr_s[pick_s];
  assign sel_end_s   = end_arr_s[pick_s];

`ifdef ADDR_JOB_ARBITER_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] BURST_MASK = ADDR_WIDTH'(BURST_BYTES - 1);
  assign misalign_s = ((sel_start_s & BURST_MASK) != '0) ||
                      (((sel_end_s - sel_start_s) & BURST_MASK) != '0);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and next-output computation for the job FSM.
  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    gnt_d            = gnt_q;
    gen_id_d         = gen_id_q;
    gen_start_addr_d = gen_start_addr_q;
    gen_end_addr_d   = gen_end_addr_q;
    gen_start_d      = 1'b0;
    req_ready_d      = '0;
    req_done_d       = '0;
    req_err_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid != '0) begin
          gnt_d            = pick_s;
          gen_id_d         = ID_WIDTH'(pick_s);
          gen_start_addr_d = sel_start_s;
          gen_end_addr_d   = sel_end_s;
          req_ready_d      = onehot(pick_s);
          if (misalign_s) begin
            req_err_d = onehot(pick_s);
            rr_d      = next_rr(pick_s);
          end else if (sel_start_s == sel_end_s) begin
            state_d = ST_COMPLETE;
          end else begin
            state_d     = ST_LAUNCH;
            gen_start_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The edge that sees gen_done high with gen_start asserted is the accept edge.
      ST_LAUNCH: begin
        if (bus.gen_done) begin
          state_d = ST_WAIT_LOW;
        end else begin
          gen_start_d = 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (!bus.gen_done) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.gen_done) begin
          state_d = ST_COMPLETE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_COMPLETE: begin
        req_done_d = onehot(gnt_q);
        rr_d       = next_rr(gnt_q);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rr_q             <= '0;
      gnt_q            <= '0;
      gen_id_q         <= '0;
      gen_start_addr_q <= '0;
      gen_end_addr_q   <= '0;
      gen_start_q      <= 1'b0;
      busy_q           <= 1'b0;
      req_ready_q      <= '0;
      req_done_q       <= '0;
      req_err_q        <= '0;
    end else begin
      state_q          <= state_d;
      rr_q             <= rr_d;
      gnt_q            <= gnt_d;
      gen_id_q         <= gen_id_d;
      gen_start_addr_q <= gen_start_addr_d;
      gen_end_addr_q   <= gen_end_addr_d;
      gen_start_q      <= gen_start_d;
      busy_q           <= busy_d;
      req_ready_q      <= req_ready_d;
      req_done_q       <= req_done_d;
      req_err_q        <= req_err_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.req_done       = req_done_q;
  assign bus.req_err        = req_err_q;
  assign bus.gen_start      = gen_start_q;
  assign bus.gen_start_addr = gen_start_addr_q;
  assign bus.gen_end_addr   = gen_end_addr_q;
  assign bus.gen_id         = gen_id_q;
  assign bus.busy           = busy_q;

  addr_job_arbiter_chk #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .ID_WIDTH    (ID_WIDTH),
    .BURST_BYTES (BURST_BYTES)
  ) u_chk (
    .aclk      (aclk),
    .reset     (reset),
    .req_ready (req_ready_q),
    .req_done  (req_done_q),
    .req_err   (req_err_q),
    .gen_start (gen_start_q),
    .busy      (busy_q),
    .gnt       (gnt_q)
  );
endmodule

// Structural invariants of the arbiter outputs.
module addr_job_arbiter_chk #(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_WIDTH    = 8,
  parameter int BURST_BYTES = 128
) (
  input logic                           aclk,
  input logic                           reset,
  input logic [NUM_CLIENTS-1:0]         req_ready,
  input logic [NUM_CLIENTS-1:0]         req_done,
  input logic [NUM_CLIENTS-1:0]         req_err,
  input logic                           gen_start,
  input logic                           busy,
  input logic [$clog2(NUM_CLIENTS)-1:0] gnt
);
  a_params: assert property (@(posedge aclk)
    ((BURST_BYTES & (BURST_BYTES - 1)) == 0) && (ID_WIDTH >= $clog2(NUM_CLIENTS)));
  a_ready_onehot: assert property (@(posedge aclk) disable iff (reset) $onehot0(req_ready));
  a_done_onehot:  assert property (@(posedge aclk) disable iff (reset) $onehot0(req_done));
  a_err_with_rdy: assert property (@(posedge aclk) disable iff (reset) (req_err & ~req_ready) == '0);
  a_start_busy:   assert property (@(posedge aclk) disable iff (reset) gen_start |-> busy);
  a_gnt_range:    assert property (@(posedge aclk) disable iff (reset) int'(gnt) < NUM_CLIENTS);
endmodule
